fetch_queue: RTL and testbench

- Instruction fetch stage with a small prefetch buffer; feeds the decode stage.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a FIFO.
- Presents the FIFO head to decode with a valid/stall handshake.
- Accepts a branch redirect (pc_src/branch_target) from the memory stage and flushes all younger work.

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with PC-tagged prefetch FIFO feeding decode
//
// Purpose:
//   Holds the fetch PC, issues word reads to a synchronous instruction memory
//   (1-cycle read latency), buffers returned instructions tagged with their PC
//   in a DEPTH-entry FIFO and presents the FIFO head to decode. A redirect
//   (pc_src) flushes the FIFO and discards the response still in flight.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds saturating fetch_count (pops) and bubble_count
//   (cycles with valid_if=0 outside reset) outputs.
//
// Ports:
//   clk             clock, all state on rising edge
//   reset           synchronous active-high reset
//   pc_src          redirect request, acts at this edge
//   branch_target   redirect PC, bits [1:0] ignored
//   stall_id        decode cannot accept the head this cycle
//   imem_req        instruction memory read request
//   imem_addr       read address (word aligned)
//   imem_rdata      read data, valid the cycle after imem_req
//   instruction_if  FIFO head instruction
//   cur_pc_if       PC of FIFO head
//   valid_if        head is valid
//   fetch_count     (FETCH_PERF_CNT_EN) number of instructions handed to decode
//   bubble_count    (FETCH_PERF_CNT_EN) number of cycles with no valid head

module fetch_queue #(
  parameter int WORD                  = 64,
  parameter int INSTR_LEN             = 32,
  parameter int DEPTH                 = 4,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  input  logic                 stall_id,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] instruction_if,
  output logic [WORD-1:0]      cur_pc_if,
  output logic                 valid_if
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          bubble_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WORD-1:0] ALIGN_MASK = ~WORD'(3);
  localparam logic [WORD-1:0] RST_PC = RESET_PC & ALIGN_MASK;

  logic [WORD-1:0]      pc;
  logic [WORD-1:0]      pend_pc;
  logic                 inflight;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [INSTR_LEN-1:0] instr_mem [DEPTH];
  logic [WORD-1:0]      pc_mem    [DEPTH];
  logic [INSTR_LEN-1:0] last_instr;
  logic [WORD-1:0]      last_pc;

  logic                 credit_ok;
  logic                 push;
  logic                 pop;
  logic [WORD-1:0]      target_aligned;

  assign target_aligned = branch_target & ALIGN_MASK;

  // Credit counts the response already in flight, so a push can never find
  // the FIFO full without a matching pop.
  assign credit_ok = (count + CW'(inflight)) < CW'(DEPTH);
  assign imem_req  = !reset && !pc_src && credit_ok;
  assign imem_addr = pc;

  // A response returns exactly one cycle after its request. A redirect at
  // the same edge kills it (the whole non-redirect branch below is skipped).
  assign push = inflight;

  assign valid_if = (count != '0);
  assign pop      = valid_if && !stall_id;

  // Head is read straight from FIFO storage; when empty, the last shown
  // values are held so decode sees stable (or zero after reset) outputs.
  assign instruction_if = valid_if ? instr_mem[rd_ptr] : last_instr;
  assign cur_pc_if      = valid_if ? pc_mem[rd_ptr]    : last_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RST_PC;
      pend_pc    <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else begin
      if (valid_if) begin
        last_instr <= instr_mem[rd_ptr];
        last_pc    <= pc_mem[rd_ptr];
      end
      if (pc_src) begin
        pc       <= target_aligned;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) begin
          pc      <= pc + WORD'(4);
          pend_pc <= pc;
        end
        inflight <= imem_req;
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage carries no reset; it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (!reset && !pc_src && push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= pend_pc;
      assert (pop || (count != CW'(DEPTH)));
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      // A pop requested during a redirect is discarded, so it is not counted.
      if (pop && !pc_src && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (!valid_if && (bubble_count != 32'hFFFF_FFFF)) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with queue-based reference model

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [63:0] branch_target;
  logic        stall_id;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_if;
  logic [63:0] cur_pc_if;
  logic        valid_if;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  fetch_queue #(.WORD(64), .INSTR_LEN(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .reset(reset),
    .pc_src(pc_src),
    .branch_target(branch_target),
    .stall_id(stall_id),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instruction_if(instruction_if),
    .cur_pc_if(cur_pc_if),
    .valid_if(valid_if)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  // Reference model: what the fetch stage should hold, in plain terms.
  ent_t        mq[$];
  bit          m_pend;
  logic [63:0] m_pend_pc;
  logic [63:0] m_pc;
  logic [31:0] m_last_i;
  logic [63:0] m_last_pc;
  logic [31:0] m_pops;
  logic [31:0] m_bub;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] t;
    t = (a >> 2) + 64'h1000;
    return t[31:0];
  endfunction

  // Advance one clock: update the model from the current inputs, clock the
  // DUT, and let the memory answer whatever the DUT requested.
  task automatic tick();
    bit          mreq;
    logic [63:0] maddr;
    bit          v;
    bit          rq;
    mreq  = imem_req;
    maddr = imem_addr;
    v  = (mq.size() != 0);
    rq = !reset && !pc_src && ((mq.size() + int'(m_pend)) < DEPTH);
    if (reset) begin
      mq.delete();
      m_pend    = 0;
      m_pend_pc = '0;
      m_pc      = 64'h0;
      m_last_i  = '0;
      m_last_pc = '0;
      m_pops    = '0;
      m_bub     = '0;
    end else begin
      if (!v && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      if (v && !stall_id && !pc_src && m_pops != 32'hFFFF_FFFF) m_pops = m_pops + 1;
      if (v) begin
        m_last_i  = mq[0].instr;
        m_last_pc = mq[0].pc;
      end
      if (pc_src) begin
        mq.delete();
        m_pend = 0;
        m_pc   = branch_target & ~64'd3;
      end else begin
        if (v && !stall_id) void'(mq.pop_front());
        if (m_pend) mq.push_back('{instr: mem_word(m_pend_pc), pc: m_pend_pc});
        if (rq) begin
          m_pend    = 1;
          m_pend_pc = m_pc;
          m_pc      = m_pc + 64'd4;
        end else begin
          m_pend = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    imem_rdata = mreq ? mem_word(maddr) : $urandom;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    pc_src   = 1'b0;
    stall_id = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    pc_src   = 1'b1;
    stall_id = 1'b0;
    branch_target = 64'h500;
    tick();
    tick();
    #2;
    n_checks++; if (valid_if !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid_if); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
    n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", imem_addr); end
    n_checks++; if (instruction_if !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %0h expected 0", instruction_if); end
    n_checks++; if (cur_pc_if !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", cur_pc_if); end
    reset  = 1'b0;
    pc_src = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      #2;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_req[%0d]: got %0b expected 1", k, imem_req); end
      n_checks++; if (imem_addr !== 64'(4 * k)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %0h expected %0h", k, imem_addr, 4 * k); end
      n_checks++; if (valid_if !== (k >= 2)) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, valid_if, k >= 2); end
      if (k >= 2) begin
        n_checks++; if (cur_pc_if !== 64'(4 * (k - 2))) begin n_fail++; $display("FAIL stream_pc[%0d]: got %0h expected %0h", k, cur_pc_if, 4 * (k - 2)); end
        n_checks++; if (instruction_if !== 32'(32'h1000 + k - 2)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %0h expected %0h", k, instruction_if, 32'h1000 + k - 2); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    stall_id = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      n_checks++; if (imem_req !== (k < 4)) begin n_fail++; $display("FAIL stall_req[%0d]: got %0b expected %0b", k, imem_req, k < 4); end
      if (k < 4) begin
        n_checks++; if (imem_addr !== 64'(4 * k)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0h expected %0h", k, imem_addr, 4 * k); end
      end
      if (k >= 2) begin
        n_checks++; if (valid_if !== 1'b1 || cur_pc_if !== 64'h0 || instruction_if !== 32'h1000) begin
          n_fail++; $display("FAIL stall_head[%0d]: got v=%0b pc=%0h i=%0h expected v=1 pc=0 i=1000", k, valid_if, cur_pc_if, instruction_if);
        end
      end
      tick();
    end
    stall_id = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_checks++; if (valid_if !== 1'b1 || cur_pc_if !== 64'(4 * k)) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%0b pc=%0h expected v=1 pc=%0h", k, valid_if, cur_pc_if, 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    stall_id = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    pc_src        = 1'b1;
    branch_target = 64'h203;
    #2;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_same: got %0b expected 0", imem_req); end
    tick();
    pc_src   = 1'b0;
    stall_id = 1'b0;
    #2;
    n_checks++; if (valid_if !== 1'b0) begin n_fail++; $display("FAIL redir_valid1: got %0b expected 0", valid_if); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin n_fail++; $display("FAIL redir_addr: got req=%0b addr=%0h expected req=1 addr=200", imem_req, imem_addr); end
    tick();
    #2;
    n_checks++; if (valid_if !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got %0b expected 0", valid_if); end
    tick();
    #2;
    n_checks++; if (valid_if !== 1'b1 || cur_pc_if !== 64'h200 || instruction_if !== 32'h1080) begin
      n_fail++; $display("FAIL redir_first: got v=%0b pc=%0h i=%0h expected v=1 pc=200 i=1080", valid_if, cur_pc_if, instruction_if);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 3; k++) tick();
    pc_src        = 1'b1;
    branch_target = 64'h100;
    #2;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req0: got %0b expected 0", imem_req); end
    tick();
    branch_target = 64'h300;
    #2;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req1: got %0b expected 0", imem_req); end
    tick();
    pc_src = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'(64'h300 + 4 * k)) begin
        n_fail++; $display("FAIL b2b_addr[%0d]: got req=%0b addr=%0h expected req=1 addr=%0h", k, imem_req, imem_addr, 64'h300 + 4 * k);
      end
      n_checks++; if (valid_if !== (k >= 2)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected %0b", k, valid_if, k >= 2); end
      if (k >= 2) begin
        n_checks++; if (cur_pc_if !== 64'(64'h300 + 4 * (k - 2))) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %0h expected %0h", k, cur_pc_if, 64'h300 + 4 * (k - 2)); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    stall_id = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    #2;
    n_checks++; if (valid_if !== 1'b0 || imem_req !== 1'b0 || instruction_if !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_hold: got v=%0b req=%0b i=%0h expected v=0 req=0 i=0", valid_if, imem_req, instruction_if);
    end
    tick();
    reset    = 1'b0;
    stall_id = 1'b0;
    #2;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || valid_if !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_restart: got req=%0b addr=%0h v=%0b expected req=1 addr=0 v=0", imem_req, imem_addr, valid_if);
    end
    tick();
    tick();
    #2;
    n_checks++; if (valid_if !== 1'b1 || cur_pc_if !== 64'h0 || instruction_if !== 32'h1000) begin
      n_fail++; $display("FAIL rstmid_first: got v=%0b pc=%0h i=%0h expected v=1 pc=0 i=1000", valid_if, cur_pc_if, instruction_if);
    end
    tick();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    #2;
    n_checks++; if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin
      n_fail++; $display("FAIL perf_reset: got f=%0d b=%0d expected 0 0", fetch_count, bubble_count);
    end
    for (int k = 0; k < 20; k++) begin
      stall_id      = (k >= 5 && k < 10);
      pc_src        = (k == 12);
      branch_target = 64'h40;
      tick();
    end
    pc_src   = 1'b0;
    stall_id = 1'b0;
    #2;
    n_checks++; if (fetch_count !== m_pops) begin n_fail++; $display("FAIL perf_fetch: got %0d expected %0d", fetch_count, m_pops); end
    n_checks++; if (bubble_count !== m_bub) begin n_fail++; $display("FAIL perf_bubble: got %0d expected %0d", bubble_count, m_bub); end
  endtask
`endif

  task automatic test_random();
    bit          e_valid;
    bit          e_req;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(63) == 0);
      pc_src   = ($urandom_range(15) == 0);
      stall_id = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0: branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        1: branch_target = {$urandom, $urandom};
        default: branch_target = 64'($urandom_range(4095));
      endcase
      #2;
      e_valid = (mq.size() != 0);
      e_req   = !reset && !pc_src && ((mq.size() + int'(m_pend)) < DEPTH);
      e_instr = e_valid ? mq[0].instr : m_last_i;
      e_pc    = e_valid ? mq[0].pc : m_last_pc;
      n_checks++; if (valid_if !== e_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", k, valid_if, e_valid); end
      n_checks++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %0b expected %0b", k, imem_req, e_req); end
      n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", k, imem_addr, m_pc); end
      n_checks++; if (instruction_if !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %0h expected %0h", k, instruction_if, e_instr); end
      n_checks++; if (cur_pc_if !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %0h expected %0h", k, cur_pc_if, e_pc); end
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if (fetch_count !== m_pops || bubble_count !== m_bub) begin
        n_fail++; $display("FAIL rnd_perf[%0d]: got f=%0d b=%0d expected f=%0d b=%0d", k, fetch_count, bubble_count, m_pops, m_bub);
      end
`endif
      tick();
    end
  endtask

  initial begin
    reset         = 1'b1;
    pc_src        = 1'b0;
    branch_target = '0;
    stall_id      = 1'b0;
    imem_rdata    = '0;
    m_pend        = 0;
    m_pend_pc     = '0;
    m_pc          = '0;
    m_last_i      = '0;
    m_last_pc     = '0;
    m_pops        = '0;
    m_bub         = '0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
